// File: rtl/id_ex_stage_if.sv
// Decode->stage and stage->ALU buses; master drives the payload and valid, slave drives ready.
// No storage here: latency and backpressure belong entirely to the stage that uses them.
interface id_ex_dec_if #(
    parameter int WIDTH = 32,
    parameter int CTRLW = 3
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic [WIDTH-1:0] ImmExt;
    logic             ALUSrc;
    logic [CTRLW-1:0] ALUControl_in;
    logic             RegWrite_in;
    logic [4:0]       Rd_in;
    logic             flush;

    modport master (
        output in_valid, RD1, RD2, ImmExt, ALUSrc, ALUControl_in, RegWrite_in, Rd_in, flush,
        input  in_ready
    );
    modport slave (
        input  in_valid, RD1, RD2, ImmExt, ALUSrc, ALUControl_in, RegWrite_in, Rd_in, flush,
        output in_ready
    );
endinterface

interface id_ex_alu_if #(
    parameter int WIDTH = 32,
    parameter int CTRLW = 3
) ();
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [CTRLW-1:0] ALUControl;
    logic             RegWrite;
    logic [4:0]       Rd;

    modport master (
        output out_valid, SrcA, SrcB, ALUControl, RegWrite, Rd,
        input  out_ready
    );
    modport slave (
        input  out_valid, SrcA, SrcB, ALUControl, RegWrite, Rd,
        output out_ready
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX boundary register with 2-entry skid: 1-cycle latency, 1/cycle throughput;
// in_ready comes only from skid occupancy, so out_ready never reaches decode combinationally.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int CTRLW = 3,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    id_ex_dec_if.slave      dec,
    id_ex_alu_if.master     alu,
    output logic [CNTW-1:0] stall_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [CTRLW-1:0] ctrl;
        logic             rw;
        logic [4:0]       rd;
    } pay_t;

    // S_BOTH means main and skid both hold an entry; skid is never occupied alone.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_MAIN  = 2'd1,
        S_BOTH  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    pay_t            r_main;
    pay_t            r_skid;
    pay_t            w_cap;
    logic [CNTW-1:0] r_stall_cnt;

    logic w_main_vld;
    logic w_skid_vld;
    logic w_in_rdy;
    logic w_in_fire;
    logic w_out_fire;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;
    logic w_stall;
    logic w_cnt_sat;

    assign w_main_vld = (r_state != S_EMPTY);
    assign w_skid_vld = (r_state == S_BOTH);
    assign w_in_rdy   = ~w_skid_vld;
    assign w_in_fire  = dec.in_valid & w_in_rdy;
    assign w_out_fire = w_main_vld & alu.out_ready;

    // B-source mux resolved here so later ALUSrc changes cannot disturb held entries.
    always_comb begin
        w_cap      = '0;
        w_cap.a    = dec.RD1;
        w_cap.b    = dec.ALUSrc ? dec.ImmExt : dec.RD2;
        w_cap.ctrl = dec.ALUControl_in;
        w_cap.rw   = dec.RegWrite_in;
        w_cap.rd   = dec.Rd_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (dec.flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_ld_main_in = 1'b1;
                        w_state_nxt  = S_MAIN;
                    end
                end
                S_MAIN: begin
                    if (w_out_fire) begin
                        if (w_in_fire) begin
                            w_ld_main_in = 1'b1;
                        end else begin
                            w_state_nxt = S_EMPTY;
                        end
                    end else if (w_in_fire) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = S_BOTH;
                    end
                end
                S_BOTH: begin
                    if (w_out_fire) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = S_MAIN;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // Payload registers may keep stale contents after a flush; the valid state masks them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main <= w_cap;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_cap;
            end
        end
    end

    assign w_stall   = w_main_vld & ~alu.out_ready & ~dec.flush;
    assign w_cnt_sat = &r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    assign dec.in_ready   = w_in_rdy;
    assign alu.out_valid  = w_main_vld;
    assign alu.SrcA       = r_main.a;
    assign alu.SrcB       = r_main.b;
    assign alu.ALUControl = r_main.ctrl;
    assign alu.RegWrite   = r_main.rw & w_main_vld;
    assign alu.Rd         = r_main.rd;
    assign stall_cnt      = r_stall_cnt;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Registered decode-to-execute boundary stage. It sits directly upstream of the ALU and feeds its A, B and ALUControl inputs.
- It captures decoded operands and control, resolves the immediate-vs-register B-source mux at capture time, and presents stable operands to the ALU.
- Valid/ready handshake on both sides with a 2-entry skid buffer, so a downstream stall never creates a combinational ready path back to decode.
- Also provides a synchronous flush for branch redirect and a saturating stall counter for performance debug.

Parameters:
WIDTH, 32, datapath width of operands and immediate
CTRLW, 3, ALU control width
CNTW, 16, width of stall-cycle counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  decode presents a valid instruction
in_ready  output  1  stage can accept this cycle
RD1  input  WIDTH  register operand 1
RD2  input  WIDTH  register operand 2
ImmExt  input  WIDTH  sign-extended immediate
ALUSrc  input  1  1 = B from ImmExt, 0 = B from RD2
ALUControl_in  input  CTRLW  ALU operation code
RegWrite_in  input  1  writeback enable
Rd_in  input  5  destination register index
flush  input  1  discard all held and incoming instructions
SrcA  output  WIDTH  to ALU A
SrcB  output  WIDTH  to ALU B
ALUControl  output  CTRLW  to ALU
RegWrite  output  1  qualified writeback enable
Rd  output  5  destination index
out_valid  output  1  SrcA/SrcB/ALUControl/Rd valid
out_ready  input  1  execute side accepts
stall_cnt  output  CNTW  saturating count of stalled cycles

Behaviour:
- Storage: main slot (drives all outputs) plus skid slot. Each slot has a valid bit and a payload: {A, B, ctrl, RegWrite, Rd}.
- Payload captured as A = RD1, B = ALUSrc ? ImmExt : RD2. Selection is resolved at capture; changes to ALUSrc afterwards have no effect on held entries.
- in_ready = ~skid_valid. It is purely registered-state derived, with no combinational path from out_ready.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; out_valid = main_valid.
- RegWrite output = main RegWrite & main_valid.
- Reset (async, asserted): both valid bits 0, all payload 0, stall_cnt 0. Visible result: out_valid 0, SrcA/SrcB 0, ALUControl 0, RegWrite 0, Rd 0, in_ready 1. Deassertion mid-stream discards everything.
- Per-cycle update, priority order:
  1. flush = 1: main_valid and skid_valid cleared; in_fire data dropped; payload registers may hold stale data. stall_cnt unchanged.
  2. main empty: in_fire loads main.
  3. main full, out_fire, skid valid: skid moves to main. Any in_fire is impossible in this case (in_ready 0).
  4. main full, out_fire, skid empty: in_fire loads main; otherwise main_valid becomes 0.
  5. main full, no out_fire, in_fire: input loads skid; in_ready drops next cycle.
  6. main full, no out_fire, no in_fire: hold.
- Latency: accepted in cycle N, visible on outputs in cycle N+1. Throughput is 1 instruction/cycle with out_ready held high.
- Ordering: strictly FIFO. No loss or duplication except via flush.
- Outputs are stable while out_valid & ~out_ready.
- stall_cnt increments when out_valid & ~out_ready & ~flush, and saturates at all-ones; it is never wrapped. Cleared only by rst.
- Simultaneous flush and out_fire: the out_fire completes downstream this cycle; the stage is empty next cycle.

Test Plan:
- Reset: assert rst mid-stream with both slots full -> out_valid 0, SrcA/SrcB 0, in_ready 1 immediately; after release, first input appears at N+1.
- Stream: out_ready 1; feed RD1=5, RD2=3, ALUSrc 0, ctrl 001, then RD1=7, ImmExt=0xFFFFFFFF, ALUSrc 1 -> outputs (5,3,001) at N+1, then (7,0xFFFFFFFF) at N+2; no gaps.
- Backpressure: out_ready 0, feed A1, A2, A3 -> A1 held in main, A2 in skid, in_ready 0, A3 not accepted. Raise out_ready -> A1, A2, A3 emerge in order with no loss.
- Flush: both slots full, flush 1 with in_valid 1 -> next cycle out_valid 0, in_ready 1; the flushed input never appears on outputs.
- RegWrite gating: RegWrite_in 1 captured, then stage drains to empty -> RegWrite output 0 whenever out_valid 0.
- Counter: CNTW=4, hold out_valid 1 and out_ready 0 for 20 cycles -> stall_cnt 15 (saturated); flush cycles do not increment; rst returns it to 0.
